// File: rtl/aes_ctr_block_gen_if.sv
// Control and counter-block stream bundle between the CTR controller and aes_ctr_block_gen.
// The master modport is the message controller/consumer side; slave is the generator.
interface aes_ctr_block_gen_if #(
  parameter int BLOCK_SIZE = 128,
  parameter int LEN_WIDTH  = 16
);
  logic                  start;
  logic [BLOCK_SIZE-1:0] iv;
  logic [LEN_WIDTH-1:0]  num_blocks;
  logic                  abort;
  logic [BLOCK_SIZE-1:0] ctr_block;
  logic                  ctr_valid;
  logic                  ctr_ready;
  logic                  ctr_last;
  logic                  busy;
  logic                  done;
  logic                  wrap_err;

  modport master (
    output start, iv, num_blocks, abort, ctr_ready,
    input  ctr_block, ctr_valid, ctr_last, busy, done, wrap_err
  );

  modport slave (
    input  start, iv, num_blocks, abort, ctr_ready,
    output ctr_block, ctr_valid, ctr_last, busy, done, wrap_err
  );
endinterface

// File: rtl/aes_ctr_block_gen.sv
// CTR-mode counter block generator: emits nonce||counter blocks under valid/ready,
// incrementing only the low CTR_WIDTH bits, with done/abort/wrap reporting.
module aes_ctr_block_gen #(
  parameter int BLOCK_SIZE = 128,
  parameter int CTR_WIDTH  = 32,
  parameter int LEN_WIDTH  = 16
) (
  input logic                clk,
  input logic                rst,
  aes_ctr_block_gen_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                state_q;
  logic [BLOCK_SIZE-1:0] ctr_q;
  logic [BLOCK_SIZE-1:0] ctr_d;
  logic [LEN_WIDTH-1:0]  rem_q;
  logic                  valid_q;
  logic                  last_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  wrap_q;

  logic [CTR_WIDTH-1:0]  low_inc;
  logic                  low_all_ones;
  logic                  handshake;

  assign low_inc      = ctr_q[CTR_WIDTH-1:0] + CTR_WIDTH'(1);
  assign low_all_ones = &ctr_q[CTR_WIDTH-1:0];
  assign handshake    = valid_q && bus.ctr_ready;

  // The nonce field above the counter is carried through untouched.
  generate
    if (CTR_WIDTH < BLOCK_SIZE) begin : g_split
      assign ctr_d = {ctr_q[BLOCK_SIZE-1:CTR_WIDTH], low_inc};
    end else begin : g_full
      assign ctr_d = low_inc;
    end
  endgenerate

  // NOTE: every register here uses non-blocking assignment so all state updates
  // see the pre-edge values; later assignments in the block override earlier ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ctr_q   <= '0;
      rem_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            ctr_q  <= bus.iv;
            rem_q  <= bus.num_blocks;
            wrap_q <= 1'b0;
            if (bus.num_blocks != '0) begin
              state_q <= ST_RUN;
              valid_q <= 1'b1;
              busy_q  <= 1'b1;
              last_q  <= (bus.num_blocks == LEN_WIDTH'(1));
            end else begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end
          end
        end

        ST_RUN: begin
          if (handshake) begin
            ctr_q <= ctr_d;
            rem_q <= rem_q - LEN_WIDTH'(1);
            if (rem_q == LEN_WIDTH'(1)) begin
              state_q <= ST_DONE;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              last_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              last_q <= (rem_q == LEN_WIDTH'(2));
              if (low_all_ones) wrap_q <= 1'b1;
            end
          end
          // Abort lands after any same-cycle handshake has been accounted for.
          if (bus.abort) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        end

        ST_DONE: begin
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ctr_block = ctr_q;
  assign bus.ctr_valid = valid_q;
  assign bus.ctr_last  = last_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.wrap_err  = wrap_q;

endmodule

// File: doc/aes_ctr_block_gen.md
Name: aes_ctr_block_gen

Overview:
- Upstream neighbour of the unrolled AES-256 round datapath in the CTR path.
- Produces the counter blocks (nonce || counter) that form the cipher input, one per accepted block, under valid/ready flow control.
- Loaded once per message with an IV and a block count. Increments the low CTR_WIDTH bits per block, per the SP800-38A standard incrementing function.
- Reports completion, abort and counter-field wrap.

Parameters:
- BLOCK_SIZE, 128, width of IV and counter block.
- CTR_WIDTH, 32, width of the incrementing low field (1..BLOCK_SIZE).
- LEN_WIDTH, 16, width of the block-count input.

Ports:
- clk  input  1  single clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  load request; honoured only in IDLE
- iv  input  BLOCK_SIZE  initial counter block, sampled when start is accepted
- num_blocks  input  LEN_WIDTH  blocks to emit, sampled when start is accepted
- abort  input  1  terminate the current message
- ctr_block  output  BLOCK_SIZE  current counter block (feeds round datapath input_text)
- ctr_valid  output  1  ctr_block valid
- ctr_ready  input  1  downstream accepts ctr_block
- ctr_last  output  1  qualifies ctr_block as the final block of the message
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse on normal completion
- wrap_err  output  1  sticky: counter field wrapped during this message

Behaviour:
- Reset (sync, rst=1 at a rising edge):
  - State goes to IDLE.
  - ctr_block=0, ctr_valid=0, ctr_last=0, busy=0, done=0, wrap_err=0, internal remaining count=0.
  - Reset mid-message discards everything. No done pulse.
- States:
  - IDLE: start=1 with num_blocks!=0 gives RUN next cycle.
    - ctr_block<=iv, remaining<=num_blocks, wrap_err<=0.
    - ctr_valid=1 in the first RUN cycle, one cycle after start.
  - IDLE: start=1 with num_blocks==0 gives DONE next cycle. No block is emitted. wrap_err<=0.
  - RUN: busy=1, ctr_valid=1. ctr_last=1 iff remaining==1.
  - Handshake is ctr_valid && ctr_ready. On each handshake:
    - The low CTR_WIDTH bits increment mod 2^CTR_WIDTH. The upper BLOCK_SIZE-CTR_WIDTH bits are never modified.
    - remaining decrements by 1.
    - If remaining==1, go to DONE next cycle with ctr_valid=0.
    - Otherwise stay in RUN and present the next block in the next cycle. Zero bubbles: one block per cycle while ctr_ready=1.
  - Wrap: a handshake with low field all-ones and remaining>1 sets wrap_err=1. The counter wraps to 0 and emission continues. wrap_err holds until the next accepted start or rst. Wrap on the last block (remaining==1) does not set wrap_err.
  - DONE: lasts one cycle. done=1, busy=0, ctr_valid=0, then IDLE.
- Handshake rules:
  - While ctr_valid=1 and ctr_ready=0, ctr_block and ctr_last hold stable.
  - ctr_valid never deasserts without a handshake, except on abort or rst.
  - ctr_ready is ignored when ctr_valid=0.
- Abort:
  - abort=1 in RUN gives IDLE next cycle: ctr_valid=0, busy=0, no done.
  - A handshake in the same cycle as abort still counts (counter and remaining update), then abort applies.
  - abort in IDLE or DONE has no effect.
  - abort and start together in IDLE: start wins.
- start in RUN or DONE is ignored; iv and num_blocks are not sampled.
- rst has priority over abort, start and handshake.
- ctr_block keeps its last value in IDLE and DONE. Only ctr_valid qualifies it.
- All outputs are registered. No combinational path from ctr_ready to ctr_valid or ctr_block.

Test Plan:
- Basic run:
  - Stimulus: rst, then start with iv=0x000102030405060708090A0B00000000, num_blocks=3, ctr_ready=1.
  - Required: ctr_valid high 1 cycle after start for 3 consecutive cycles. Blocks end ..00000000, ..00000001, ..00000002. ctr_last only on the third block. done pulses the cycle after the third handshake. wrap_err=0.
- Backpressure:
  - Stimulus: same load, ctr_ready toggling 1,0,0,1,0,1.
  - Required: ctr_block and ctr_last stable while ctr_ready=0. Exactly 3 handshakes with values 0,1,2 in the low field. Single done pulse.
- Wrap:
  - Stimulus: iv low field=0xFFFFFFFE, upper field=0xAA..AA, num_blocks=4.
  - Required: low fields FFFFFFFE, FFFFFFFF, 00000000, 00000001. Upper field unchanged. wrap_err rises after the second handshake and stays 1 after done. The next start clears it.
- Zero length:
  - Stimulus: start with num_blocks=0.
  - Required: ctr_valid never asserts. done pulses 1 cycle after start. busy stays 0.
- Abort mid-message:
  - Stimulus: num_blocks=10. Assert abort together with the 4th handshake.
  - Required: ctr_valid=0 the next cycle, no done. A following start with iv=0 restarts the low field at 0.
- Reset and ignored start:
  - Stimulus: start while in RUN with a different iv → ignored, sequence continues unchanged. Then rst=1 mid-message.
  - Required: next cycle has all outputs 0 and state IDLE. No done pulse.
